// File: rtl/eds_pkt_buffer_pkg.sv
// eds_pkt_buffer_pkg: shared constants, write-FSM state encoding and the
// FIFO word layout for the EDS packet buffer.
//   EDS_ENC_WORDS    encoder words (X, W) leading every EDS packet
//   EDS_DATA_LEN_DEF default data words per packet
//   wr_state_e       one-hot write-side states
//   fifo_word_t      {last, data} as stored in the buffer RAM
//   sat_inc          saturating 32-bit increment for the statistics counters
package eds_pkt_buffer_pkg;

  localparam int EDS_ENC_WORDS    = 2;
  localparam int EDS_DATA_LEN_DEF = 1024;
  localparam int EDS_WORD_W       = 64;

  typedef enum logic [3:0] {
    WR_IDLE = 4'b0001,
    WR_ENC  = 4'b0010,
    WR_DATA = 4'b0100,
    WR_DROP = 4'b1000
  } wr_state_e;

  typedef struct packed {
    logic                  last;
    logic [EDS_WORD_W-1:0] data;
  } fifo_word_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eds_pkt_buffer_if.sv
// eds_pkt_buffer_if: AXI-Stream link from the packet buffer to the DMA path.
//   tvalid/tdata/tlast  driven by the master (packet buffer)
//   tready              driven by the slave (downstream consumer)
interface eds_pkt_buffer_if #(
  parameter int DW = 64
);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;

  modport master (output tvalid, tdata, tlast, input  tready);
  modport slave  (input  tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/eds_pkt_buffer_ram.sv
// eds_buf_ram: simple dual-port RAM, one write port, one registered read port.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read request; rdata_o valid the cycle after re_i
//   rdata_o          holds its value when re_i is low
module eds_buf_ram #(
  parameter int AW = 11,
  parameter int DW = 65
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/eds_pkt_buffer.sv
// eds_pkt_buffer: splits the EDS word stream into X/W encoder words and
// EDS_DATA_LEN data words, buffers data in a commit/rollback FIFO so only
// complete packets become readable, and streams them out on AXI-Stream.
// Ports:
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   eds_rx_start_i       session level (rising edge = new session)
//   eds_rxen_i/rxdata_i  EDS word strobe and word
//   x/w_encode_o         encoder words of the last committed packet
//   encode_vld_o         1-cycle pulse when x/w_encode_o update
//   m_axis               AXI-Stream master (tvalid/tdata/tlast/tready)
//   pkt_ok_cnt_o         committed packets this session (saturating)
//   pkt_drop_cnt_o       dropped packets this session (saturating)
//   overflow_o           sticky overflow flag, cleared on session start
// Build option: define EDS_PKT_STAT_EN to keep the counters and overflow
// flag; otherwise those three ports are tied to 0.
module eds_pkt_buffer
  import eds_pkt_buffer_pkg::*;
#(
  parameter int EDS_DATA_LEN = EDS_DATA_LEN_DEF,
  parameter int FIFO_AW      = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  eds_rx_start_i,
  input  logic                  eds_rxen_i,
  input  logic [EDS_WORD_W-1:0] eds_rxdata_i,
  output logic [EDS_WORD_W-1:0] x_encode_o,
  output logic [EDS_WORD_W-1:0] w_encode_o,
  output logic                  encode_vld_o,
  eds_pkt_buffer_if.master      m_axis,
  output logic [31:0]           pkt_ok_cnt_o,
  output logic [31:0]           pkt_drop_cnt_o,
  output logic                  overflow_o
);
  localparam int PW = FIFO_AW + 1;
  localparam int IW = (EDS_DATA_LEN > 1) ? $clog2(EDS_DATA_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(EDS_DATA_LEN - 1);

  wr_state_e             state;
  logic                  start_q;
  logic [IW-1:0]         idx;
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr;
  logic [EDS_WORD_W-1:0] x_q, w_q;
  logic rise, fall, full, empty, last_w, wr_go, we, commit, ovf_drop;
  fifo_word_t            wr_word, ram_q, o_word, s_word;
  logic                  ram_vld, o_vld, s_vld, pop, issue;
  logic [1:0]            occ_n;

  assign rise     = eds_rx_start_i & ~start_q;
  assign fall     = ~eds_rx_start_i & start_q;
  // Pointers carry one extra MSB: equal index with differing MSB = full.
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty    = (rd_ptr == commit_ptr);   // reader sees committed data only
  assign last_w   = (idx == LAST_IDX);
  assign wr_go    = (state == WR_DATA) && eds_rxen_i && !fall;
  assign we       = wr_go && !full;
  assign commit   = we && last_w;
  assign ovf_drop = wr_go && full;

  assign wr_word.last = last_w;
  assign wr_word.data = eds_rxdata_i;

  // ---------------- write side ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= WR_IDLE;
      start_q      <= 1'b0;
      idx          <= '0;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      x_q          <= '0;
      w_q          <= '0;
      x_encode_o   <= '0;
      w_encode_o   <= '0;
      encode_vld_o <= 1'b0;
    end else begin
      start_q      <= eds_rx_start_i;
      encode_vld_o <= 1'b0;
      if (rise) idx <= '0;
      if (fall && state != WR_IDLE) begin
        // Session ended mid-packet: discard everything since the last commit.
        wr_ptr <= commit_ptr;
        idx    <= '0;
        state  <= WR_IDLE;
      end else begin
        unique case (state)
          WR_IDLE: if (eds_rx_start_i && eds_rxen_i) begin
            x_q   <= eds_rxdata_i;
            state <= WR_ENC;
          end
          WR_ENC: if (eds_rxen_i) begin
            w_q   <= eds_rxdata_i;
            idx   <= '0;
            state <= WR_DATA;
          end
          WR_DATA: if (eds_rxen_i) begin
            idx <= last_w ? '0 : idx + 1'b1;
            if (ovf_drop) begin
              wr_ptr <= commit_ptr;
              // If the overflowing word was the last one, nothing is left to skip.
              state  <= last_w ? WR_IDLE : WR_DROP;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              if (commit) begin
                commit_ptr   <= wr_ptr + 1'b1;
                x_encode_o   <= x_q;
                w_encode_o   <= w_q;
                encode_vld_o <= 1'b1;
                state        <= WR_IDLE;
              end
            end
          end
          WR_DROP: if (eds_rxen_i) begin
            idx <= last_w ? '0 : idx + 1'b1;
            if (last_w) state <= WR_IDLE;
          end
          default: state <= WR_IDLE;
        endcase
      end
    end
  end

  eds_buf_ram #(.AW(FIFO_AW), .DW($bits(fifo_word_t))) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wr_ptr[FIFO_AW-1:0]),
    .wdata_i (wr_word),
    .re_i    (issue),
    .raddr_i (rd_ptr[FIFO_AW-1:0]),
    .rdata_o (ram_q)
  );

  // ---------------- read side ----------------
  // Words in flight (RAM output) plus held words (output reg + skid) never
  // exceed two, so a new read is issued only if a slot is free after the
  // current RAM word lands and any pop completes.
  assign pop   = o_vld & m_axis.tready;
  assign occ_n = 2'(o_vld) + 2'(s_vld) + 2'(ram_vld) - 2'(pop);
  assign issue = !empty && (occ_n < 2'd2);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr  <= '0;
      ram_vld <= 1'b0;
      o_vld   <= 1'b0;
      s_vld   <= 1'b0;
      o_word  <= '0;
      s_word  <= '0;
    end else begin
      ram_vld <= issue;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (pop) begin
        if (s_vld) begin
          o_word <= s_word;
          if (ram_vld) s_word <= ram_q;
          else         s_vld  <= 1'b0;
        end else if (ram_vld) begin
          o_word <= ram_q;
        end else begin
          o_vld  <= 1'b0;
        end
      end else if (ram_vld) begin
        if (!o_vld) begin
          o_vld  <= 1'b1;
          o_word <= ram_q;
        end else begin
          s_vld  <= 1'b1;
          s_word <= ram_q;
        end
      end
    end
  end

  assign m_axis.tvalid = o_vld;
  assign m_axis.tdata  = o_word.data;
  assign m_axis.tlast  = o_word.last;

  // ---------------- statistics ----------------
`ifdef EDS_PKT_STAT_EN
  logic fall_drop;
  assign fall_drop = fall && (state == WR_ENC || state == WR_DATA);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || rise) begin
      pkt_ok_cnt_o   <= '0;
      pkt_drop_cnt_o <= '0;
      overflow_o     <= 1'b0;
    end else begin
      if (commit)               pkt_ok_cnt_o   <= sat_inc(pkt_ok_cnt_o);
      if (ovf_drop || fall_drop) pkt_drop_cnt_o <= sat_inc(pkt_drop_cnt_o);
      if (ovf_drop)             overflow_o     <= 1'b1;
    end
  end
`else
  assign pkt_ok_cnt_o   = '0;
  assign pkt_drop_cnt_o = '0;
  assign overflow_o     = 1'b0;
`endif

endmodule

// File: tb/tb_eds_pkt_buffer.sv
module tb_eds_pkt_buffer;
  import eds_pkt_buffer_pkg::*;

  localparam int LEN = 1024;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rxen = 1'b0;
  logic [63:0] rxdata = '0;
  logic [63:0] x_enc, w_enc;
  logic        enc_vld, ovf;
  logic [31:0] ok_cnt, drop_cnt;

  eds_pkt_buffer_if axis ();

  eds_pkt_buffer #(.EDS_DATA_LEN(LEN), .FIFO_AW(11)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .eds_rx_start_i (start),
    .eds_rxen_i     (rxen),
    .eds_rxdata_i   (rxdata),
    .x_encode_o     (x_enc),
    .w_encode_o     (w_enc),
    .encode_vld_o   (enc_vld),
    .m_axis         (axis),
    .pkt_ok_cnt_o   (ok_cnt),
    .pkt_drop_cnt_o (drop_cnt),
    .overflow_o     (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected value of a statistics port: real value only when the stats build is used.
  function automatic logic [63:0] st(input logic [63:0] v);
`ifdef EDS_PKT_STAT_EN
    return v;
`else
    return 64'(v & 64'h0);
`endif
  endfunction

  // tready driver: fixed level or 50% random
  bit   rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;
  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Monitor: collect beats, count encode pulses, check AXIS hold rules.
  logic [64:0] got_q[$];
  int          enc_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_word = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        check("axis_hold_valid_last", 64'({axis.tvalid, axis.tlast}), 64'({1'b1, prev_word[64]}));
        check("axis_hold_data", axis.tdata, prev_word[63:0]);
      end
      if (axis.tvalid && axis.tready) got_q.push_back({axis.tlast, axis.tdata});
      if (enc_vld) enc_cnt <= enc_cnt + 1;
      prev_stall <= axis.tvalid && !axis.tready;
      prev_word  <= {axis.tlast, axis.tdata};
    end
  end

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic new_session();
    tick(); start = 1'b0;
    tick(); tick(); start = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input logic [63:0] x, input logic [63:0] w,
                          input logic [63:0] base, input int ndata);
    tick(); rxen = 1'b1; rxdata = x;
    tick(); rxdata = w;
    for (int i = 0; i < ndata; i++) begin
      tick(); rxdata = base + 64'(i);
    end
    tick(); rxen = 1'b0; rxdata = '0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(); c++;
    end
  endtask

  // Pops one packet from the collected beats and compares against base..base+LEN-1.
  task automatic check_pkt(input string name, input logic [63:0] base);
    int nbad = 0;
    logic [64:0] exp, got;
    for (int i = 0; i < LEN; i++) begin
      exp = {(i == LEN-1), base + 64'(i)};
      if (got_q.size() == 0) nbad++;
      else begin
        got = got_q.pop_front();
        if (got !== exp) begin
          if (nbad == 0) $display("  %s: first bad beat %0d got %0h exp %0h", name, i, got, exp);
          nbad++;
        end
      end
    end
    check(name, 64'(nbad), 64'd0);
  endtask

  typedef struct {
    bit          new_sess;
    bit          rnd;
    logic [63:0] x, w, base;
    logic [31:0] exp_ok;
  } vec_t;
  vec_t vecs[9];

  int e0;

  initial begin
    // table: packet 0 = single packet at full rate; 1..8 = random-ready session
    vecs[0] = '{1'b1, 1'b0, 64'h1, 64'h2, 64'h0, 32'd1};
    vecs[1] = '{1'b1, 1'b1, 64'hA001, 64'hB001, 64'h0001_0000_0000_0000, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 64'hA002, 64'hB002, 64'h0002_0000_0000_0000, 32'd2};
    vecs[3] = '{1'b0, 1'b1, 64'hA003, 64'hB003, 64'h0003_0000_0000_0000, 32'd3};
    vecs[4] = '{1'b0, 1'b1, 64'hA004, 64'hB004, 64'h0004_0000_0000_0000, 32'd4};
    vecs[5] = '{1'b0, 1'b1, 64'hA005, 64'hB005, 64'h0005_0000_0000_0000, 32'd5};
    vecs[6] = '{1'b0, 1'b1, 64'hA006, 64'hB006, 64'h0006_0000_0000_0000, 32'd6};
    vecs[7] = '{1'b0, 1'b1, 64'hA007, 64'hB007, 64'h0007_0000_0000_0000, 32'd7};
    vecs[8] = '{1'b0, 1'b1, 64'hA008, 64'hB008, 64'hFFFF_FFFF_FFFF_FF00, 32'd8};

    // reset state
    repeat (3) tick();
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", axis.tdata, 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_xw", x_enc | w_enc, 64'd0);
    check("rst_enc_vld", 64'(enc_vld), 64'd0);
    check("rst_stats", 64'({ok_cnt, drop_cnt} | 64'(ovf)), 64'd0);
    rst_n = 1'b1;

    // scenarios 1 and 4: table-driven packets
    for (int k = 0; k < 9; k++) begin
      if (vecs[k].new_sess) new_session();
      rdy_rand = vecs[k].rnd;
      rdy_fix  = 1'b1;
      e0 = enc_cnt;
      send_pkt(vecs[k].x, vecs[k].w, vecs[k].base, LEN);
      wait_beats(LEN, 8000);
      check_pkt($sformatf("pkt%0d_data", k), vecs[k].base);
      check("enc_pulses", 64'(enc_cnt - e0), 64'd1);
      check("x_encode", x_enc, vecs[k].x);
      check("w_encode", w_enc, vecs[k].w);
      check("ok_cnt", 64'(ok_cnt), st(64'(vecs[k].exp_ok)));
    end
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    repeat (4) tick();

    // scenario 2: stalled output, third packet overflows
    new_session();
    rdy_fix = 1'b0;
    repeat (3) tick();
    e0 = enc_cnt;
    send_pkt(64'hC1, 64'hD1, 64'h0100_0000, LEN);
    send_pkt(64'hC2, 64'hD2, 64'h0200_0000, LEN);
    send_pkt(64'hC3, 64'hD3, 64'h0300_0000, LEN);
    repeat (5) tick();
    check("s2_no_beats_stalled", 64'(got_q.size()), 64'd0);
    check("s2_tvalid_held", 64'(axis.tvalid), 64'd1);
    check("s2_ok_cnt", 64'(ok_cnt), st(64'd2));
    check("s2_drop_cnt", 64'(drop_cnt), st(64'd1));
    check("s2_overflow", 64'(ovf), st(64'd1));
    check("s2_enc_pulses", 64'(enc_cnt - e0), 64'd2);
    check("s2_x_encode", x_enc, 64'hC2);
    rdy_fix = 1'b1;
    wait_beats(2*LEN, 5000);
    check_pkt("s2_pkt_a", 64'h0100_0000);
    check_pkt("s2_pkt_b", 64'h0200_0000);
    repeat (10) tick();
    check("s2_no_extra_beats", 64'(got_q.size()), 64'd0);
    check("s2_tvalid_idle", 64'(axis.tvalid), 64'd0);

    // scenario 3: session drops after data word 500
    new_session();
    check("s3_ovf_cleared", 64'(ovf), 64'd0);
    check("s3_drop_cleared", 64'(drop_cnt), 64'd0);
    send_pkt(64'hE1, 64'hF1, 64'h0400_0000, 501);
    start = 1'b0;
    repeat (20) tick();
    check("s3_no_beats", 64'(got_q.size()), 64'd0);
    check("s3_drop_cnt", 64'(drop_cnt), st(64'd1));
    check("s3_ok_cnt", 64'(ok_cnt), 64'd0);
    new_session();
    send_pkt(64'hE2, 64'hF2, 64'h0500_0000, LEN);
    wait_beats(LEN, 3000);
    check_pkt("s3_next_pkt", 64'h0500_0000);
    check("s3_x_encode", x_enc, 64'hE2);

    // scenario 5: 1-cycle reset mid-packet with a committed packet pending
    new_session();
    rdy_fix = 1'b0;
    send_pkt(64'h51, 64'h61, 64'h0600_0000, LEN);
    send_pkt(64'h52, 64'h62, 64'h0700_0000, 300);
    check("s5_tvalid_before_rst", 64'(axis.tvalid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s5_rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("s5_rst_tdata", axis.tdata, 64'd0);
    check("s5_rst_tlast", 64'(axis.tlast), 64'd0);
    check("s5_rst_xw", x_enc | w_enc, 64'd0);
    check("s5_rst_enc_vld", 64'(enc_vld), 64'd0);
    check("s5_rst_stats", 64'({ok_cnt, drop_cnt} | 64'(ovf)), 64'd0);
    rdy_fix = 1'b1;
    repeat (6) tick();
    check("s5_fifo_empty", 64'(got_q.size()), 64'd0);
    check("s5_tvalid_empty", 64'(axis.tvalid), 64'd0);
    send_pkt(64'h53, 64'h63, 64'h0800_0000, LEN);
    wait_beats(LEN, 3000);
    check_pkt("s5_next_pkt", 64'h0800_0000);
    check("s5_ok_cnt", 64'(ok_cnt), st(64'd1));
    check("s5_w_encode", w_enc, 64'h63);
    repeat (5) tick();
    check("s5_no_extra_beats", 64'(got_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
